// File: rtl/alu_exec_unit_pkg.sv
// Shared constants for the EX-stage ALU: operation codes, alu_op/func encodings,
// sequencer state encoding and the instruction decoder.
package alu_exec_unit_pkg;

    typedef enum logic [3:0] {
        OP_OFF   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_NOR   = 4'd5,
        OP_SLT   = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8,
        OP_MULTU = 4'd9,
        OP_DIVU  = 4'd10
    } alu_oper_t;

    localparam logic [1:0] ALUOP_MTYPE = 2'b00;
    localparam logic [1:0] ALUOP_BTYPE = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_JTYPE = 2'b11;

    localparam logic [5:0] FUNC_ADD   = 6'b100000;
    localparam logic [5:0] FUNC_SUB   = 6'b100010;
    localparam logic [5:0] FUNC_AND   = 6'b100100;
    localparam logic [5:0] FUNC_OR    = 6'b100101;
    localparam logic [5:0] FUNC_NOR   = 6'b100111;
    localparam logic [5:0] FUNC_SLT   = 6'b101010;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic alu_oper_t decode_op(input logic [1:0] alu_op, input logic [5:0] func);
        alu_oper_t op;
        op = OP_OFF;
        case (alu_op)
            ALUOP_MTYPE: op = OP_ADD;
            ALUOP_BTYPE: op = OP_SUB;
            ALUOP_RTYPE: begin
                case (func)
                    FUNC_ADD:   op = OP_ADD;
                    FUNC_SUB:   op = OP_SUB;
                    FUNC_AND:   op = OP_AND;
                    FUNC_OR:    op = OP_OR;
                    FUNC_NOR:   op = OP_NOR;
                    FUNC_SLT:   op = OP_SLT;
                    FUNC_MFHI:  op = OP_MFHI;
                    FUNC_MFLO:  op = OP_MFLO;
                    FUNC_MULTU: op = OP_MULTU;
                    FUNC_DIVU:  op = OP_DIVU;
                    default:    op = OP_OFF;
                endcase
            end
            default: op = OP_OFF;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_exec_unit_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide datapath.
// prod_hi/prod_lo present the result of the step taken at the next edge.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] count;
    logic             mode_div;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;

    // Multiply keeps the multiplier in acc_lo and shifts the sum in from the top;
    // divide keeps the dividend in acc_lo and the partial remainder in acc_hi.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (mode_div) begin
            if (!div_diff[WIDTH]) begin
                prod_hi = div_diff[WIDTH-1:0];
                prod_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                prod_hi = div_shift[WIDTH-1:0];
                prod_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            prod_hi = mul_sum[WIDTH:1];
            prod_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            mode_div <= 1'b0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (go) begin
            count    <= CNT_W'(WIDTH);
            mode_div <= is_div;
            opnd     <= b;
            acc_hi   <= '0;
            acc_lo   <= a;
        end else if (count != '0) begin
            count  <= count - 1'b1;
            acc_hi <= prod_hi;
            acc_lo <= prod_lo;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: combinational single-cycle ops plus HI/LO and a stalling
// iterative MULTU/DIVU sequencer.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             stall,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    alu_oper_t        op;
    state_t           state;
    state_t           state_next;
    logic             go;
    logic             is_div;
    logic             last;
    logic             dz_flag;
    logic             div_by_zero;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;

    assign op          = decode_op(alu_op, func);
    assign div_by_zero = (state == ST_IDLE) && start && (op == OP_DIVU) && (b == '0);

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk     (clk),
        .rst     (rst),
        .go      (go),
        .is_div  (is_div),
        .a       (a),
        .b       (b),
        .last    (last),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        go         = 1'b0;
        is_div     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && op == OP_MULTU) begin
                    go         = 1'b1;
                    state_next = ST_MUL;
                end else if (start && op == OP_DIVU) begin
                    if (b != '0) begin
                        go         = 1'b1;
                        is_div     = 1'b1;
                        state_next = ST_DIV;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (last) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // HI/LO only move on a completion edge; an aborted operation never reaches them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi      <= '0;
            lo      <= '0;
            dz_flag <= 1'b0;
        end else begin
            dz_flag <= div_by_zero;
            if (div_by_zero) begin
                hi <= a;
                lo <= '1;
            end else if ((state == ST_MUL || state == ST_DIV) && last) begin
                hi <= prod_hi;
                lo <= prod_lo;
            end
        end
    end

    assign done     = (state == ST_DONE);
    assign div_zero = done && dz_flag;
    assign stall    = !rst && (((state == ST_IDLE) && start && (op == OP_MULTU || op == OP_DIVU))
                               || state == ST_MUL || state == ST_DIV);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOR:  result = ~(a | b);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule
